// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
//   Bundles the instruction/memory status inputs and all datapath control
//   outputs of the multicycle MIPS main control FSM.
//
//   master : the control FSM (reads opcode/mem_ready, drives controls)
//   slave  : the datapath side (drives opcode/mem_ready, reads controls)
//
//   opcode        IR[31:26], valid from DECODE onward
//   mem_ready     memory completed the current access this cycle
//   pc_write      unconditional PC load
//   pc_write_cond PC load qualified by ALU zero (beq)
//   i_or_d        memory address select: 0 = PC, 1 = ALUOut
//   mem_read      memory read request
//   mem_write     memory write request
//   ir_write      instruction register load
//   mem_to_reg    write-back source: 0 = ALUOut, 1 = MDR
//   reg_dst       destination select: 0 = rt, 1 = rd
//   reg_write     register file write enable
//   alu_src_a     ALU A select: 0 = PC, 1 = A register
//   alu_src_b     ALU B select: 00 B, 01 const 4, 10 imm, 11 imm << 2
//   alu_op        ALU control code: 00 add, 01 sub, 10 decode funct
//   pc_source     PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   illegal_op    one-cycle pulse on an unsupported opcode
//   mem_timeout   one-cycle pulse on memory wait expiry
// ----------------------------------------------------------------------------
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multicycle MIPS datapath. Sequences fetch,
//   decode, execute, memory and write-back over a shared ALU and a unified
//   memory, waits on mem_ready in memory states and flags bad opcodes.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset (state IDLE, all outputs 0)
//     bus    multicycle_control_if.master (opcode/mem_ready in, controls out)
//
//   Parameter:
//     MEM_TIMEOUT  wait cycles tolerated in FETCH/MEM_READ/MEM_WRITE before
//                  mem_timeout pulses and the FSM returns to FETCH; 0 = off
// ----------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    R_WB      = 4'd8,
    EXEC_I    = 4'd9,
    I_WB      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // A zero timeout still needs a legal one-bit counter.
  localparam int              CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam bit              TMO_EN    = (MEM_TIMEOUT != 0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_wait_state;
  logic             w_timeout;

  assign w_wait_state = (r_state == FETCH) || (r_state == MEM_READ) ||
                        (r_state == MEM_WRITE);

  // mem_ready wins over an expiring count on the same cycle.
  assign w_timeout = TMO_EN && w_wait_state && !bus.mem_ready &&
                     (r_wait_cnt == CNT_LIMIT);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      // Any state change (including a timeout back into FETCH) is an entry
      // into the destination state, so the wait count restarts there.
      if (w_timeout || (w_next != r_state))
        r_wait_cnt <= '0;
      else if (TMO_EN && w_wait_state && !bus.mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next            = r_state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.illegal_op    = 1'b0;
    bus.mem_timeout   = 1'b0;

    if (w_timeout) begin
      // Abort the stalled access: all controls stay low for this cycle.
      bus.mem_timeout = 1'b1;
      w_next          = FETCH;
    end else begin
      unique case (r_state)
        IDLE: w_next = FETCH;

        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          // PC+4 and IR load only commit once the instruction word is back.
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
          if (bus.mem_ready) w_next = DECODE;
        end

        DECODE: begin
          // Branch target precompute into ALUOut.
          bus.alu_src_b = 2'b11;
          case (bus.opcode)
            OP_LW, OP_SW: w_next = MEM_ADDR;
            OP_RTYPE:     w_next = EXEC_R;
            OP_ADDI:      w_next = EXEC_I;
            OP_BEQ:       w_next = BRANCH;
            OP_J:         w_next = JUMP;
            default: begin
              bus.illegal_op = 1'b1;
              w_next         = FETCH;
            end
          endcase
        end

        MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          w_next        = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
        end

        MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (bus.mem_ready) w_next = MEM_WB;
        end

        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          w_next         = FETCH;
        end

        MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (bus.mem_ready) w_next = FETCH;
        end

        EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
          w_next        = R_WB;
        end

        R_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
          w_next        = FETCH;
        end

        EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          w_next        = I_WB;
        end

        I_WB: begin
          bus.reg_write = 1'b1;
          w_next        = FETCH;
        end

        BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
          w_next            = FETCH;
        end

        JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
          w_next        = FETCH;
        end

        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control (MEM_TIMEOUT = 8). Each cycle
//   the stimulus pushes the control word the specification requires for the
//   intended state onto a scoreboard queue; the word is popped and compared
//   against the DUT outputs on the falling edge.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  typedef enum int {
    T_IDLE, T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_READ, T_MEM_WB, T_MEM_WRITE,
    T_EXEC_R, T_R_WB, T_EXEC_I, T_I_WB, T_BRANCH, T_JUMP, T_TMO
  } tst_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  ctl_t sb_q[$];

  multicycle_control_if bus ();

  multicycle_control #(.MEM_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Required control word for a state, written straight from the state table.
  function automatic ctl_t exp_ctl(tst_t st, logic mr, logic ill);
    ctl_t c = '0;
    case (st)
      T_FETCH:     begin c.mem_read = 1; c.alu_src_b = 2'b01;
                         c.ir_write = mr; c.pc_write = mr; end
      T_DECODE:    begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
      T_MEM_ADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      T_MEM_READ:  begin c.mem_read = 1; c.i_or_d = 1; end
      T_MEM_WB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
      T_MEM_WRITE: begin c.mem_write = 1; c.i_or_d = 1; end
      T_EXEC_R:    begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      T_R_WB:      begin c.reg_write = 1; c.reg_dst = 1; end
      T_EXEC_I:    begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      T_I_WB:      begin c.reg_write = 1; end
      T_BRANCH:    begin c.alu_src_a = 1; c.alu_op = 2'b01;
                         c.pc_write_cond = 1; c.pc_source = 2'b01; end
      T_JUMP:      begin c.pc_write = 1; c.pc_source = 2'b10; end
      T_TMO:       begin c.mem_timeout = 1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t obs();
    ctl_t c;
    c.pc_write      = bus.pc_write;
    c.pc_write_cond = bus.pc_write_cond;
    c.i_or_d        = bus.i_or_d;
    c.mem_read      = bus.mem_read;
    c.mem_write     = bus.mem_write;
    c.ir_write      = bus.ir_write;
    c.mem_to_reg    = bus.mem_to_reg;
    c.reg_dst       = bus.reg_dst;
    c.reg_write     = bus.reg_write;
    c.alu_src_a     = bus.alu_src_a;
    c.alu_src_b     = bus.alu_src_b;
    c.alu_op        = bus.alu_op;
    c.pc_source     = bus.pc_source;
    c.illegal_op    = bus.illegal_op;
    c.mem_timeout   = bus.mem_timeout;
    return c;
  endfunction

  // Called at posedge+1: drive mem_ready, queue the expected word, compare on
  // the falling edge, return at the next posedge+1.
  task automatic step(input string tag, input tst_t st, input logic mr,
                      input logic ill = 1'b0);
    ctl_t got;
    ctl_t exp;
    bus.mem_ready = mr;
    sb_q.push_back(exp_ctl(st, mr, ill));
    @(negedge clk);
    got = obs();
    exp = sb_q.pop_front();
    check(tag, 32'(got), 32'(exp));
    check({tag, "_excl"},
          {30'd0, bus.mem_read & bus.mem_write, bus.reg_write & bus.mem_write},
          32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = OP_RTYPE;
    #1;
    check("rst_zero", 32'(obs()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_hold", 32'(obs()), 32'd0);
    rst_n = 1'b1;

    // Release: IDLE for one cycle, then FETCH waits for mem_ready.
    step("idle", T_IDLE, 1'b1);
    step("fetch_wait", T_FETCH, 1'b0);
    check("fetch_pcw_low", {31'd0, bus.pc_write}, 32'd0);

    // lw, no wait states: 5 cycles.
    bus.opcode = OP_LW;
    step("lw_fetch", T_FETCH, 1'b1);
    step("lw_dec", T_DECODE, 1'b1);
    step("lw_addr", T_MEM_ADDR, 1'b1);
    step("lw_read", T_MEM_READ, 1'b1);
    step("lw_wb", T_MEM_WB, 1'b1);

    // R-type: 4 cycles.
    bus.opcode = OP_RTYPE;
    step("r_fetch", T_FETCH, 1'b1);
    step("r_dec", T_DECODE, 1'b1);
    step("r_exec", T_EXEC_R, 1'b1);
    step("r_wb", T_R_WB, 1'b1);

    // addi: 4 cycles.
    bus.opcode = OP_ADDI;
    step("i_fetch", T_FETCH, 1'b1);
    step("i_dec", T_DECODE, 1'b1);
    step("i_exec", T_EXEC_I, 1'b1);
    step("i_wb", T_I_WB, 1'b1);

    // beq and j: 3 cycles each.
    bus.opcode = OP_BEQ;
    step("beq_fetch", T_FETCH, 1'b1);
    step("beq_dec", T_DECODE, 1'b1);
    step("beq_br", T_BRANCH, 1'b1);
    bus.opcode = OP_J;
    step("j_fetch", T_FETCH, 1'b1);
    step("j_dec", T_DECODE, 1'b1);
    step("j_jump", T_JUMP, 1'b1);

    // sw with three wait cycles: mem_write held four cycles, no timeout.
    bus.opcode = OP_SW;
    step("sw_fetch", T_FETCH, 1'b1);
    step("sw_dec", T_DECODE, 1'b1);
    step("sw_addr", T_MEM_ADDR, 1'b1);
    for (int i = 0; i < 3; i++) step("sw_wait", T_MEM_WRITE, 1'b0);
    step("sw_done", T_MEM_WRITE, 1'b1);

    // lw: mem_ready arrives exactly when the count hits the limit -> no timeout.
    bus.opcode = OP_LW;
    step("lwr_fetch", T_FETCH, 1'b1);
    step("lwr_dec", T_DECODE, 1'b1);
    step("lwr_addr", T_MEM_ADDR, 1'b1);
    for (int i = 0; i < 8; i++) step("lwr_wait", T_MEM_READ, 1'b0);
    step("lwr_edge", T_MEM_READ, 1'b1);
    step("lwr_wb", T_MEM_WB, 1'b1);

    // lw: mem_ready never arrives -> timeout pulse after 8 waits, back to FETCH.
    step("lwt_fetch", T_FETCH, 1'b1);
    step("lwt_dec", T_DECODE, 1'b1);
    step("lwt_addr", T_MEM_ADDR, 1'b1);
    for (int i = 0; i < 8; i++) step("lwt_wait", T_MEM_READ, 1'b0);
    step("lwt_tmo", T_TMO, 1'b0);

    // Timeout in FETCH itself, then a clean restart of the fetch.
    for (int i = 0; i < 8; i++) step("ft_wait", T_FETCH, 1'b0);
    step("ft_tmo", T_TMO, 1'b0);

    // Illegal opcode: pulse in DECODE, straight back to FETCH.
    bus.opcode = OP_BAD;
    step("ill_fetch", T_FETCH, 1'b1);
    step("ill_dec", T_DECODE, 1'b1, 1'b1);
    step("ill_back", T_FETCH, 1'b1);

    // Reset asserted during a MEM_READ wait clears outputs asynchronously.
    bus.opcode = OP_LW;
    step("ar_dec", T_DECODE, 1'b1);
    step("ar_addr", T_MEM_ADDR, 1'b1);
    step("ar_wait", T_MEM_READ, 1'b0);
    bus.mem_ready = 1'b0;
    #2;
    check("ar_pre", {31'd0, bus.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_async", 32'(obs()), 32'd0);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    #1;
    check("ar_held", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    step("ar_idle", T_IDLE, 1'b1);
    step("ar_fetch", T_FETCH, 1'b1);
    step("ar_dec2", T_DECODE, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back for one shared ALU and one shared unified memory. It drives the 2-bit opAlu code consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct. It waits on a ready/valid-style memory handshake and flags unsupported opcodes.

Parameters:
- MEM_TIMEOUT, 8, maximum cycles spent waiting for mem_ready in a memory state before mem_timeout is pulsed and the FSM returns to FETCH; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- alu_op  out  2  opAlu to the ALU control decoder.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- mem_timeout  out  1  one-cycle pulse on memory wait expiry.

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP. State register uses a 4-bit encoding.
- Reset:
  - While rst_n = 0, state is IDLE and every output is 0.
  - The first rising edge after release moves IDLE -> FETCH.
  - Reset asserted mid-instruction aborts it immediately, with no partial register or memory write.
- Outputs are a Moore decode of the state, except that pc_write and ir_write in FETCH are additionally gated by mem_ready. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute).
  - Next state by opcode: 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000000 -> EXEC_R; 001000 (addi) -> EXEC_I; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP.
  - Any other opcode pulses illegal_op and goes to FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1, i_or_d = 1. Held until mem_ready = 1, then -> MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Then -> FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Held until mem_ready = 1, then -> FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Then -> R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Then -> FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Then -> I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Then -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Then -> FETCH.
- JUMP: pc_write = 1, pc_source = 10. Then -> FETCH.
- Latency with zero memory wait:
  - lw = 5 cycles; sw, R-type, addi = 4; beq, j = 3.
  - Each wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments on each cycle in one of those states with mem_ready = 0.
  - If it reaches MEM_TIMEOUT (and MEM_TIMEOUT != 0), mem_timeout pulses for 1 cycle, all outputs are 0 in that cycle, and the next state is FETCH. Counter width is clog2(MEM_TIMEOUT+1).
  - If mem_ready = 1 arrives on the same cycle the count reaches the limit, mem_ready wins: normal transition, no timeout.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.

Test Plan:
- Reset and release -> all outputs 0 during reset and in IDLE; FETCH entered 1 cycle after release with mem_read = 1, alu_src_b = 01, pc_write = 0 until mem_ready.
- lw (opcode 100011), mem_ready always 1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; reg_write = 1 with mem_to_reg = 1 only in cycle 5.
- R-type (000000) -> alu_op = 10 in EXEC_R; reg_write = 1, reg_dst = 1 in cycle 4; beq (000100) -> alu_op = 01, pc_write_cond = 1 in cycle 3.
- sw with mem_ready held low 3 cycles in MEM_WRITE -> mem_write held 4 cycles, no timeout; with MEM_TIMEOUT = 8 and mem_ready held low 8 cycles -> mem_timeout pulses once, FSM returns to FETCH.
- opcode 111111 -> illegal_op pulses in DECODE, next state FETCH, no reg_write or mem_write asserted.
- rst_n asserted during MEM_READ wait -> outputs 0 immediately (asynchronously); after release, execution restarts at IDLE then FETCH.
